// File: rtl/lcd_write_sequencer.sv
// HD44780-style 4-bit LCD write sequencer: power-on init, then byte writes
// split into two E-strobed nibbles with the required setup, gap and busy waits.
module lcd_write_sequencer #(
  parameter int SETUP_CYC         = 2,
  parameter int E_HIGH_CYC        = 12,
  parameter int NIBBLE_GAP_CYC    = 50,
  parameter int BYTE_WAIT_CYC     = 2000,
  parameter int CLEAR_WAIT_CYC    = 82000,
  parameter int POWERON_CYC       = 750000,
  parameter int INIT_NIB_WAIT_CYC = 205000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iWrite,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  function automatic int at_least_one(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int EFF_SETUP = at_least_one(SETUP_CYC);
  localparam int EFF_EH    = at_least_one(E_HIGH_CYC);
  localparam int EFF_GAP   = at_least_one(NIBBLE_GAP_CYC);
  localparam int EFF_BYTE  = at_least_one(BYTE_WAIT_CYC);
  localparam int EFF_CLR   = at_least_one(CLEAR_WAIT_CYC);
  localparam int EFF_PON   = at_least_one(POWERON_CYC);
  localparam int EFF_NIBW  = at_least_one(INIT_NIB_WAIT_CYC);

  localparam int MAXV = max2(max2(max2(EFF_SETUP, EFF_EH), max2(EFF_GAP, EFF_BYTE)),
                             max2(max2(EFF_CLR, EFF_PON), EFF_NIBW));
  localparam int W    = (MAXV <= 1) ? 1 : $clog2(MAXV);

  // Counters run 0..N-1, so each phase ends when the count hits N-1.
  localparam logic [W-1:0] L_SETUP = W'(EFF_SETUP - 1);
  localparam logic [W-1:0] L_EH    = W'(EFF_EH - 1);
  localparam logic [W-1:0] L_GAP   = W'(EFF_GAP - 1);
  localparam logic [W-1:0] L_BYTE  = W'(EFF_BYTE - 1);
  localparam logic [W-1:0] L_CLR   = W'(EFF_CLR - 1);
  localparam logic [W-1:0] L_PON   = W'(EFF_PON - 1);
  localparam logic [W-1:0] L_NIBW  = W'(EFF_NIBW - 1);

  typedef enum logic [3:0] {
    POWERON, INIT_NIB, INIT_BYTE, IDLE, SETUP_HI,
    PULSE_HI, GAP, SETUP_LO, PULSE_LO, WAIT
  } state_t;

  typedef enum logic [1:0] {NIB_SETUP, NIB_PULSE, NIB_WAIT} nib_phase_t;

  state_t     state;
  nib_phase_t nib_phase;
  logic [W-1:0] cnt;
  logic [W-1:0] phase_lim;
  logic         phase_end;
  logic [1:0]   idx;
  logic [7:0]   byte_q;
  logic [7:0]   init_byte;
  logic         is_clear;

  assign oLCD_RW   = 1'b0;
  assign is_clear  = !oLCD_RS && (byte_q == 8'h01 || byte_q == 8'h02);
  assign phase_end = (cnt == phase_lim);

  always_comb begin
    unique case (idx)
      2'd0:    init_byte = 8'h28;
      2'd1:    init_byte = 8'h06;
      2'd2:    init_byte = 8'h0C;
      default: init_byte = 8'h01;
    endcase
  end

  // NOTE: every variable gets a default first so no path leaves a latch.
  always_comb begin
    phase_lim = '0;
    case (state)
      POWERON:            phase_lim = L_PON;
      INIT_NIB: begin
        case (nib_phase)
          NIB_SETUP: phase_lim = L_SETUP;
          NIB_PULSE: phase_lim = L_EH;
          default:   phase_lim = L_NIBW;
        endcase
      end
      SETUP_HI, SETUP_LO: phase_lim = L_SETUP;
      PULSE_HI, PULSE_LO: phase_lim = L_EH;
      GAP:                phase_lim = L_GAP;
      WAIT:               phase_lim = is_clear ? L_CLR : L_BYTE;
      default:            phase_lim = '0;
    endcase
  end

  // NOTE: reset is sampled only on the clock edge, so a mid-pulse reset drops E at the next edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= POWERON;
      nib_phase <= NIB_SETUP;
      cnt       <= '0;
      idx       <= '0;
      byte_q    <= '0;
      oLCD_E    <= 1'b0;
      oLCD_RS   <= 1'b0;
      oLCD_Data <= 4'h0;
      oReady    <= 1'b0;
      oInitDone <= 1'b0;
    end else begin
      cnt <= phase_end ? '0 : cnt + 1'b1;
      case (state)
        POWERON: if (phase_end) begin
          state     <= INIT_NIB;
          nib_phase <= NIB_SETUP;
          idx       <= '0;
          oLCD_Data <= 4'h3;
        end
        INIT_NIB: if (phase_end) begin
          case (nib_phase)
            NIB_SETUP: begin
              nib_phase <= NIB_PULSE;
              oLCD_E    <= 1'b1;
            end
            NIB_PULSE: begin
              nib_phase <= NIB_WAIT;
              oLCD_E    <= 1'b0;
            end
            default: begin
              nib_phase <= NIB_SETUP;
              if (idx == 2'd3) begin
                state <= INIT_BYTE;
                idx   <= '0;
              end else begin
                idx       <= idx + 2'd1;
                oLCD_Data <= (idx == 2'd2) ? 4'h2 : 4'h3;
              end
            end
          endcase
        end
        INIT_BYTE: begin
          state     <= SETUP_HI;
          byte_q    <= init_byte;
          oLCD_RS   <= 1'b0;
          oLCD_Data <= init_byte[7:4];
        end
        IDLE: if (iWrite && oReady) begin
          state     <= SETUP_HI;
          byte_q    <= iData;
          oLCD_RS   <= iRS;
          oLCD_Data <= iData[7:4];
          oReady    <= 1'b0;
        end
        SETUP_HI: if (phase_end) begin
          state  <= PULSE_HI;
          oLCD_E <= 1'b1;
        end
        PULSE_HI: if (phase_end) begin
          state  <= GAP;
          oLCD_E <= 1'b0;
        end
        GAP: if (phase_end) begin
          state     <= SETUP_LO;
          oLCD_Data <= byte_q[3:0];
        end
        SETUP_LO: if (phase_end) begin
          state  <= PULSE_LO;
          oLCD_E <= 1'b1;
        end
        PULSE_LO: if (phase_end) begin
          state  <= WAIT;
          oLCD_E <= 1'b0;
        end
        WAIT: if (phase_end) begin
          if (oInitDone || idx == 2'd3) begin
            state     <= IDLE;
            oReady    <= 1'b1;
            oInitDone <= 1'b1;
          end else begin
            state <= INIT_BYTE;
            idx   <= idx + 2'd1;
          end
        end
        default: state <= POWERON;
      endcase
    end
  end

endmodule
